// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps a 4:1 mux through channels 0..3, samples each after a settle time, hands the 4-bit frame downstream
// Ports: clk, rst (sync, active high); start, cont; mux_o from the mux; sel_s1/sel_s0 to the mux;
//        busy; frame_valid/frame_ready/frame_data handshake; frames_done accepted-frame count (wraps).
// Optional: define MUX4_SCAN_PARITY_EN to add frame_parity (XOR of frame_data, built up while sampling).
module mux4_scan_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             mux_o,
    output logic             sel_s1,
    output logic             sel_s0,
    output logic             busy,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [3:0]       frame_data,
    output logic [CNT_W-1:0] frames_done
`ifdef MUX4_SCAN_PARITY_EN
    ,
    output logic             frame_parity
`endif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [3:0] LAST   = 4'(SETTLE_CYCLES - 1);
    logic [1:0] state;
    logic [1:0] ch;
    logic [3:0] cnt;
    assign {sel_s1, sel_s0} = ch;
    assign busy = state != IDLE;
    assign frame_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch <= 2'd0;
            cnt <= 4'd0;
            frame_data <= 4'd0;
            frames_done <= '0;
`ifdef MUX4_SCAN_PARITY_EN
            frame_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SETTLE;
                    ch <= 2'd0;
                    cnt <= 4'd0;
                end
                SETTLE: begin
                    cnt <= cnt == LAST ? 4'd0 : cnt + 4'd1;
                    state <= cnt == LAST ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    frame_data[ch] <= mux_o;
`ifdef MUX4_SCAN_PARITY_EN
                    // channel 0 restarts the running XOR so stale bits from a previous frame never leak in
                    frame_parity <= (ch == 2'd0 ? 1'b0 : frame_parity) ^ mux_o;
`endif
                    ch <= ch == 2'd3 ? ch : ch + 2'd1;
                    state <= ch == 2'd3 ? DONE : SETTLE;
                end
                default: if (frame_ready) begin
                    frames_done <= frames_done + CNT_W'(1);
                    ch <= 2'd0;
                    cnt <= 4'd0;
                    state <= cont ? SETTLE : IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: randomized scoreboard bench for mux4_scan_ctrl
module tb_mux4_scan_ctrl;
`ifdef MUX4_SCAN_PARITY_EN
    localparam int SC = 3;
`else
    localparam int SC = 1;
`endif
    localparam int LAT = 4 * (SC + 1);
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic frame_ready = 1'b0;
    logic [3:0] inp = 4'd0;
    logic mux_o;
    logic sel_s1, sel_s0, busy, frame_valid;
    logic [3:0] frame_data;
    logic [7:0] frames_done;
`ifdef MUX4_SCAN_PARITY_EN
    logic frame_parity;
`endif
    mux4_scan_ctrl #(.SETTLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cont(cont),
        .mux_o(mux_o),
        .sel_s1(sel_s1),
        .sel_s0(sel_s0),
        .busy(busy),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data(frame_data),
        .frames_done(frames_done)
`ifdef MUX4_SCAN_PARITY_EN
        ,
        .frame_parity(frame_parity)
`endif
    );
    // behavioural 4:1 mux: select n routes input i(n+1), held here as inp[n]
    assign mux_o = inp[{sel_s1, sel_s0}];
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [3:0] q[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    // monitor: compares every presented frame against the queue head, tracks the accepted count and latency
    logic [7:0] exp_done = 8'd0;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;
    int t_start = 0;
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 8'd0;
            q.delete();
            prev_valid = 1'b0;
            prev_busy = 1'b0;
        end else begin
            chk("frames_done", frames_done, exp_done);
            if (frame_valid) begin
                if (q.size() == 0) chk("unexpected_frame", 1, 0);
                else begin
                    chk("frame_data", frame_data, q[0]);
`ifdef MUX4_SCAN_PARITY_EN
                    chk("frame_parity", frame_parity, ^q[0]);
`endif
                end
                if (!prev_valid) chk("latency", cyc - t_start, LAT);
            end
            if (busy && !prev_busy) t_start = cyc;
            if (frame_valid && frame_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                exp_done++;
                if (cont) t_start = cyc + 1;
            end
            prev_valid = frame_valid;
            prev_busy = busy;
        end
    end
    logic acc;
    task automatic tick;
        logic hs;
        hs = frame_valid & frame_ready;
        @(posedge clk);
        #1;
        acc = hs;
    endtask
    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask
    task automatic wait_valid(input int lim);
        int n = 0;
        while (!frame_valid && n < lim) begin
            tick;
            n++;
        end
        chk("valid_timeout", frame_valid, 1);
    endtask
    task automatic check_reset_outputs;
        chk("rst_sel", {sel_s1, sel_s0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_done", frames_done, 0);
`ifdef MUX4_SCAN_PARITY_EN
        chk("rst_parity", frame_parity, 0);
`endif
    endtask
    task automatic run_cont(input int n, input bit rnd, input bit fixed);
        int k = 0;
        int g = 0;
        cont = 1'b1;
        inp = fixed ? 4'hA : 4'($urandom);
        q.push_back(inp);
        start = 1'b1;
        tick;
        start = 1'b0;
        while (k < n && g < n * 60) begin
            frame_ready = rnd ? 1'($urandom % 2) : 1'b1;
            start = (rnd && k < n - 1) ? 1'($urandom % 2) : 1'b0;
            tick;
            g++;
            if (acc) begin
                k++;
                if (k < n) begin
                    inp = (fixed && k == 1) ? 4'h5 : 4'($urandom);
                    q.push_back(inp);
                end
                if (k == n - 1) begin
                    cont = 1'b0;
                    start = 1'b0;
                end
            end
        end
        chk("cont_frames", k, n);
        frame_ready = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        wait_idle(20);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
    initial begin
        int n;
        logic [3:0] hold;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check_reset_outputs;
        inp = 4'b1101;
        frame_ready = 1'b1;
        q.push_back(inp);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int t = 0; t < LAT; t++) begin
            chk("sel_step", {sel_s1, sel_s0}, t / (SC + 1));
            chk("busy_scan", busy, 1);
            tick;
        end
        chk("single_valid", frame_valid, 1);
        chk("single_data", frame_data, 4'b1101);
        wait_idle(10);
        chk("single_done", frames_done, 1);
        frame_ready = 1'b0;
        inp = 4'($urandom);
        q.push_back(inp);
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_valid(100);
        hold = frame_data;
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom % 2);
            tick;
            chk("bp_valid", frame_valid, 1);
            chk("bp_data", frame_data, hold);
        end
        start = 1'b0;
        frame_ready = 1'b1;
        tick;
        frame_ready = 1'b0;
        chk("bp_one_xfer", frames_done, 2);
        tick;
        tick;
        chk("bp_valid_low", frame_valid, 0);
        chk("bp_idle", busy, 0);
        run_cont(2, 1'b0, 1'b1);
        chk("cont_done", frames_done, 4);
        run_cont(20, 1'b1, 1'b0);
        chk("rand_done", frames_done, 24);
        run_cont(237, 1'b0, 1'b0);
        chk("wrap_done", frames_done, 8'd5);
        inp = 4'($urandom);
        q.push_back(inp);
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while ({sel_s1, sel_s0} != 2'd2 && n < 100) begin
            tick;
            n++;
        end
        chk("reach_ch2", {sel_s1, sel_s0}, 2);
        rst = 1'b1;
        start = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        start = 1'b0;
        check_reset_outputs;
        tick;
        inp = 4'($urandom);
        q.push_back(inp);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_sel", {sel_s1, sel_s0}, 0);
        chk("restart_busy", busy, 1);
        frame_ready = 1'b1;
        wait_idle(100);
        chk("restart_done", frames_done, 1);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
